// File: rtl/plb_cache_responder_pkg.sv
// Shared types for the PLB cache responder.
//   plb_tag_t         SPA page number used as the PLB tag
//   mpt_access_e      access type carried with each lookup
//   plb_lookup_req_t  lookup address {tag, access_type}
//   plb_entry_t       installed entry {tag, r, w, x}
//   perm_allows()     selects the permission bit that matches an access type
package plb_cache_responder_pkg;

  localparam int unsigned PLB_TAG_WIDTH       = 22;
  localparam int unsigned PLB_ENTRIES_DEFAULT = 8;

  typedef logic [PLB_TAG_WIDTH-1:0] plb_tag_t;

  typedef enum logic [1:0] {
    ACCESS_READ  = 2'd0,
    ACCESS_WRITE = 2'd1,
    ACCESS_EXEC  = 2'd2
  } mpt_access_e;

  typedef struct packed {
    plb_tag_t    tag;
    mpt_access_e access_type;
  } plb_lookup_req_t;

  typedef struct packed {
    plb_tag_t tag;
    logic     r;
    logic     w;
    logic     x;
  } plb_entry_t;

  function automatic logic perm_allows(input plb_entry_t e, input mpt_access_e a);
    logic ok;
    case (a)
      ACCESS_READ:  ok = e.r;
      ACCESS_WRITE: ok = e.w;
      ACCESS_EXEC:  ok = e.x;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/plb_cache_responder_if.sv
// PLB cache memory port (request/grant, single-beat response).
//   req/gnt   : a request is accepted in the cycle where req && gnt.
//   valid     : one-cycle response pulse, exactly one per accepted request,
//               never back-pressured by the master.
//   addr      : plb_lookup_req_t {tag, access_type}
//   rdata     : bit0 = hit, error flags a rejected (write) request.
//   wdata/be  : carried for port compatibility only.
// Modports: master = lookup stage of the walker, slave = the PLB responder.
interface plb_cache_responder_if
  import plb_cache_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = $bits(plb_lookup_req_t),
  parameter int unsigned DATA_WIDTH = 1
);
  localparam int unsigned BE_WIDTH = (DATA_WIDTH / 8 > 0) ? DATA_WIDTH / 8 : 1;

  logic                  req;
  logic                  gnt;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic                  error;

  modport master (
    output req, addr, wdata, we, be,
    input  gnt, valid, rdata, error
  );

  modport slave (
    input  req, addr, wdata, we, be,
    output gnt, valid, rdata, error
  );

endinterface

// File: rtl/plb_cache_responder_victim_select.sv
// plb_victim_select: picks the array slot a refill writes to.
//   valid_i   : per-entry valid bits
//   match_i   : per-entry "valid and tag equals refill tag"
//   ptr_i     : round-robin victim pointer
//   idx_o     : target slot
//   advance_o : high only when the victim pointer slot was used (array full, no match)
// Priority: matching entry, then lowest-index free entry, then the pointer slot.
module plb_victim_select #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [N-1:0]     match_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             advance_o
);

  logic             have_match;
  logic             have_free;
  logic [IDX_W-1:0] match_idx;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    have_match = 1'b0;
    have_free  = 1'b0;
    match_idx  = '0;
    free_idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (match_i[i] && !have_match) begin
        have_match = 1'b1;
        match_idx  = IDX_W'(i);
      end
      if (!valid_i[i] && !have_free) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end

    idx_o     = ptr_i;
    advance_o = 1'b0;
    if (have_match) begin
      idx_o = match_idx;
    end else if (have_free) begin
      idx_o = free_idx;
    end else begin
      advance_o = 1'b1;
    end
  end

endmodule

// File: rtl/plb_cache_responder.sv
// plb_cache_responder: fully-associative PLB entry array answering lookups
// from the walker's PLB stage with a 1-bit hit, one cycle after grant.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   flush_i          : invalidate all entries; blocks grant and refill that cycle
//   plb_cache_mem    : slave side of the PLB cache memory port
//   refill_valid_i   : install refill_entry_i (accepted when refill_ready_o)
//   refill_ready_o   : low during reset and flush
//   refill_entry_i   : {tag, r, w, x}
// Lookups see the array as it was at the start of the cycle; refills and
// flushes in the same cycle only affect later lookups.
module plb_cache_responder
  import plb_cache_responder_pkg::*;
#(
  parameter int unsigned PLB_ENTRIES    = PLB_ENTRIES_DEFAULT,
  parameter int unsigned PLB_ADDR_WIDTH = $bits(plb_lookup_req_t),
  parameter int unsigned PLB_DATA_WIDTH = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  plb_cache_responder_if.slave         plb_cache_mem,
  input  logic                         refill_valid_i,
  output logic                         refill_ready_o,
  input  plb_entry_t                   refill_entry_i
);

  localparam int unsigned IDX_W = $clog2(PLB_ENTRIES);

  plb_entry_t               entry_q [PLB_ENTRIES];
  logic [PLB_ENTRIES-1:0]   valid_q;
  logic [IDX_W-1:0]         victim_ptr_q;

  logic                     rsp_valid_q;
  logic                     rsp_hit_q;
  logic                     rsp_err_q;

  logic [PLB_ADDR_WIDTH-1:0] addr_raw;
  plb_lookup_req_t           lookup;
  logic                      gnt;
  logic                      lookup_hit;
  logic [PLB_ENTRIES-1:0]    refill_match;
  logic                      refill_fire;
  logic [IDX_W-1:0]          target_idx;
  logic                      ptr_advance;
  logic [PLB_DATA_WIDTH-1:0] rdata_d;
  logic                      unused_ok;

  assign addr_raw = plb_cache_mem.addr;
  assign lookup   = plb_lookup_req_t'(addr_raw);

  // wdata/be are part of the port but carry nothing for a read-only cache.
  assign unused_ok = ^{plb_cache_mem.wdata, plb_cache_mem.be};

  assign gnt            = plb_cache_mem.req && !flush_i && rst_ni;
  assign refill_ready_o = rst_ni && !flush_i;
  assign refill_fire    = refill_valid_i && refill_ready_o;

  // Tags are unique in the array, so OR-reducing the per-entry hit is exact.
  always_comb begin
    lookup_hit   = 1'b0;
    refill_match = '0;
    for (int i = 0; i < int'(PLB_ENTRIES); i++) begin
      if (valid_q[i] && entry_q[i].tag == lookup.tag &&
          perm_allows(entry_q[i], lookup.access_type)) begin
        lookup_hit = 1'b1;
      end
      refill_match[i] = valid_q[i] && (entry_q[i].tag == refill_entry_i.tag);
    end
  end

  plb_victim_select #(
    .N     (PLB_ENTRIES),
    .IDX_W (IDX_W)
  ) u_victim_select (
    .valid_i   (valid_q),
    .match_i   (refill_match),
    .ptr_i     (victim_ptr_q),
    .idx_o     (target_idx),
    .advance_o (ptr_advance)
  );

  // Valid bits and pointer carry the architectural reset state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      victim_ptr_q <= '0;
    end else if (flush_i) begin
      valid_q      <= '0;
      victim_ptr_q <= '0;
    end else if (refill_fire) begin
      valid_q[target_idx] <= 1'b1;
      if (ptr_advance) begin
        victim_ptr_q <= victim_ptr_q + 1'b1;
      end
    end
  end

  // Entry payload is meaningless while its valid bit is clear, so no reset.
  always_ff @(posedge clk_i) begin
    if (refill_fire) begin
      entry_q[target_idx] <= refill_entry_i;
    end
  end

  // Single response stage; a write request is answered with error and no hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= gnt;
      rsp_hit_q   <= gnt && !plb_cache_mem.we && lookup_hit;
      rsp_err_q   <= gnt && plb_cache_mem.we;
    end
  end

  assign rdata_d             = PLB_DATA_WIDTH'(rsp_hit_q);
  assign plb_cache_mem.gnt   = gnt;
  assign plb_cache_mem.valid = rsp_valid_q;
  assign plb_cache_mem.rdata = rdata_d;
  assign plb_cache_mem.error = rsp_err_q;

endmodule

// File: tb/tb_plb_cache_responder.sv
module tb_plb_cache_responder;
  import plb_cache_responder_pkg::*;

  localparam int unsigned AW = $bits(plb_lookup_req_t);
  localparam int unsigned DW = 1;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i;
  logic refill_valid_i;
  logic refill_ready_o;
  plb_entry_t refill_entry_i;

  always #5 clk_i = ~clk_i;

  plb_cache_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  plb_cache_responder #(
    .PLB_ENTRIES    (8),
    .PLB_ADDR_WIDTH (AW),
    .PLB_DATA_WIDTH (DW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .plb_cache_mem  (mem_if.slave),
    .refill_valid_i (refill_valid_i),
    .refill_ready_o (refill_ready_o),
    .refill_entry_i (refill_entry_i)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {error, hit} expected for one granted request.
  logic [1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Responses: a pending expectation means valid must be high this cycle.
  always @(negedge clk_i) begin
    logic [1:0] e;
    check("rsp_valid", 32'(mem_if.valid), 32'(exp_q.size() > 0));
    if (mem_if.valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_hit", 32'(mem_if.rdata), 32'(e[0]));
      check("rsp_error", 32'(mem_if.error), 32'(e[1]));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic plb_entry_t mk(input int tag, input logic r, input logic w, input logic x);
    plb_entry_t e;
    e.tag = plb_tag_t'(tag);
    e.r = r;
    e.w = w;
    e.x = x;
    return e;
  endfunction

  // One clock of stimulus: drive after the edge, check grant/ready mid-cycle,
  // then queue the expected response for the following cycle.
  task automatic step(input logic req, input int tag, input mpt_access_e acc, input logic we,
                      input logic rv, input plb_entry_t re, input logic fl,
                      input logic [1:0] exp_rsp);
    @(posedge clk_i);
    #1;
    mem_if.req     = req;
    mem_if.addr    = {plb_tag_t'(tag), acc};
    mem_if.we      = we;
    refill_valid_i = rv;
    refill_entry_i = re;
    flush_i        = fl;
    @(negedge clk_i);
    check("gnt", 32'(mem_if.gnt), 32'(req && !fl));
    if (rv) check("refill_ready", 32'(refill_ready_o), 32'(!fl));
    #1;
    if (req && !fl) exp_q.push_back(exp_rsp);
  endtask

  task automatic idle();
    step(1'b0, 0, ACCESS_READ, 1'b0, 1'b0, mk(0, 0, 0, 0), 1'b0, 2'b00);
  endtask

  task automatic lookup(input int tag, input mpt_access_e acc, input logic hit);
    step(1'b1, tag, acc, 1'b0, 1'b0, mk(0, 0, 0, 0), 1'b0, {1'b0, hit});
  endtask

  task automatic refill(input plb_entry_t e);
    step(1'b0, 0, ACCESS_READ, 1'b0, 1'b1, e, 1'b0, 2'b00);
  endtask

  task automatic flush();
    step(1'b0, 0, ACCESS_READ, 1'b0, 1'b1, mk(5, 1, 1, 1), 1'b1, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mem_if.req     = 1'b1;
    mem_if.addr    = '0;
    mem_if.wdata   = '0;
    mem_if.we      = 1'b0;
    mem_if.be      = '1;
    flush_i        = 1'b0;
    refill_valid_i = 1'b1;
    refill_entry_i = mk(9, 1, 1, 1);

    // Reset state with request and refill held high.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_gnt", 32'(mem_if.gnt), 0);
    check("rst_valid", 32'(mem_if.valid), 0);
    check("rst_rdata", 32'(mem_if.rdata), 0);
    check("rst_error", 32'(mem_if.error), 0);
    check("rst_ready", 32'(refill_ready_o), 0);
    mem_if.req     = 1'b0;
    refill_valid_i = 1'b0;
    rst_ni         = 1'b1;
    idle();

    // 1: empty array misses.
    lookup(32'h12, ACCESS_READ, 1'b0);
    idle();

    // 2: permission selects hit, back-to-back responses.
    refill(mk(32'h12, 1, 0, 0));
    lookup(32'h12, ACCESS_READ, 1'b1);
    lookup(32'h12, ACCESS_WRITE, 1'b0);
    lookup(32'h12, ACCESS_EXEC, 1'b0);
    idle();

    // 3: fill, then round-robin replacement from slot 0.
    flush();
    for (int i = 0; i < 8; i++) refill(mk(i, 1, 0, 0));
    lookup(32'h07, ACCESS_READ, 1'b1);
    refill(mk(32'h20, 1, 0, 0));
    lookup(32'h00, ACCESS_READ, 1'b0);
    lookup(32'h20, ACCESS_READ, 1'b1);
    lookup(32'h01, ACCESS_READ, 1'b1);
    refill(mk(32'h21, 1, 0, 0));
    lookup(32'h01, ACCESS_READ, 1'b0);
    lookup(32'h21, ACCESS_READ, 1'b1);
    lookup(32'h02, ACCESS_READ, 1'b1);
    // Tag match overwrites permissions without moving the pointer.
    refill(mk(32'h21, 0, 1, 0));
    refill(mk(32'h22, 1, 0, 0));
    lookup(32'h02, ACCESS_READ, 1'b0);
    lookup(32'h21, ACCESS_READ, 1'b0);
    lookup(32'h21, ACCESS_WRITE, 1'b1);
    lookup(32'h22, ACCESS_READ, 1'b1);

    // 4: same-cycle refill and lookup sees the old array (replaces slot 3).
    step(1'b1, 32'h30, ACCESS_READ, 1'b0, 1'b1, mk(32'h30, 1, 0, 0), 1'b0, 2'b00);
    lookup(32'h30, ACCESS_READ, 1'b1);
    lookup(32'h03, ACCESS_READ, 1'b0);

    // 5: flush with a response in flight.
    refill(mk(32'h12, 1, 0, 0));
    lookup(32'h12, ACCESS_READ, 1'b1);
    step(1'b1, 32'h12, ACCESS_READ, 1'b0, 1'b0, mk(0, 0, 0, 0), 1'b1, 2'b00);
    lookup(32'h12, ACCESS_READ, 1'b0);
    lookup(32'h30, ACCESS_READ, 1'b0);

    // 6: write requests are errored and leave the array alone.
    refill(mk(32'h40, 0, 0, 1));
    step(1'b1, 32'h40, ACCESS_EXEC, 1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 2'b10);
    step(1'b1, 32'h55, ACCESS_READ, 1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 2'b10);
    lookup(32'h40, ACCESS_EXEC, 1'b1);
    lookup(32'h40, ACCESS_READ, 1'b0);

    // Random lookups of absent tags must all miss.
    for (int i = 0; i < 6; i++) lookup(int'($urandom_range(32'h100, 32'h1ff)), ACCESS_READ, 1'b0);

    // Reset mid-operation drops the in-flight response and clears the array.
    lookup(32'h40, ACCESS_EXEC, 1'b1);
    rst_ni = 1'b0;
    exp_q.delete();
    mem_if.req = 1'b1;
    #2;
    check("midrst_gnt", 32'(mem_if.gnt), 0);
    check("midrst_valid", 32'(mem_if.valid), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_if.req = 1'b0;
    idle();
    lookup(32'h40, ACCESS_EXEC, 1'b0);
    idle();
    idle();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
